// File: rtl/psum_writeback_pkg.sv
// Shared sizing, types and helpers for the partial-sum writeback stage.
package psum_writeback_pkg;

  localparam int unsigned FILTER_NUM = 32;
  localparam int unsigned PEA_NUM    = 4;
  localparam int unsigned OUT_BYTES  = 16;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned CFG_W      = 9;
  localparam int unsigned CNT_W      = 18;

  localparam int unsigned VEC_BYTES = FILTER_NUM * PEA_NUM;
  localparam int unsigned VEC_W     = VEC_BYTES * 8;
  localparam int unsigned BEAT_BITS = OUT_BYTES * 8;
  localparam int unsigned BEATS     = VEC_BYTES / OUT_BYTES;
  localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [BEAT_BITS-1:0]            beat_t;
  typedef logic [BEATS-1:0][BEAT_BITS-1:0] vec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Zero every negative byte of a sum vector when enabled.
  function automatic vec_t relu_vec(input vec_t v, input logic en);
    logic [VEC_BYTES-1:0][7:0] b;
    b = v;
    for (int i = 0; i < int'(VEC_BYTES); i++) begin
      if (en && b[i][7]) b[i] = 8'h00;
    end
    return vec_t'(b);
  endfunction

endpackage

// File: rtl/psum_writeback_if.sv
// Sum-vector input and DRAM write-beat bus of the writeback stage.
interface psum_writeback_if;
  import psum_writeback_pkg::*;

  vec_t              sum_in;
  logic              sum_valid;
  beat_t             out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  sum_in, sum_valid, out_ready,
    output out_data, out_addr, out_valid
  );

  modport slave (
    output sum_in, sum_valid, out_ready,
    input  out_data, out_addr, out_valid
  );
endinterface

// File: rtl/psum_writeback_vec_fifo.sv
// Two-entry sum-vector FIFO; a push while full is legal when paired with a pop.
// Exposes the head that will be visible after the next edge so outputs can be registered.
module psum_writeback_vec_fifo
  import psum_writeback_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  vec_t push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic empty_nxt_c,
  output vec_t head_nxt_c
);

  vec_t       mem [2];
  logic       rd_ptr, wr_ptr, rd_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       push_ok, pop_ok;

  always_comb begin
    push_ok     = push && (!full || pop);
    pop_ok      = pop && !empty;
    rd_nxt      = rd_ptr ^ pop_ok;
    cnt_nxt     = cnt + 2'(push_ok) - 2'(pop_ok);
    empty_nxt_c = (cnt_nxt == 2'd0);
    head_nxt_c  = (push_ok && (wr_ptr == rd_nxt)) ? push_data : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_ptr ^ push_ok;
      cnt    <= cnt_nxt;
      full   <= (cnt_nxt == 2'd2);
      empty  <= (cnt_nxt == 2'd0);
    end
  end

endmodule

// File: rtl/psum_writeback.sv
// CCM output stage: ReLU, double-buffer and serialise sum vectors into addressed DRAM write beats.
module psum_writeback
  import psum_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CFG_W-1:0]  cfg_col,
  input  logic [CFG_W-1:0]  cfg_row,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic              relu_en,
  psum_writeback_if.master  bus,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   vec_total_q, vec_cnt_q, done_cnt_q;
  logic [BEAT_W-1:0]  beat_q, beat_nxt;
  logic               relu_q;
  logic               launch, hs, pop, want, push, drop;
  logic               fifo_full, fifo_empty, fifo_empty_nxt;
  vec_t               head_nxt;

  psum_writeback_vec_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_data   (relu_vec(bus.sum_in, relu_q)),
    .pop         (pop),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .empty_nxt_c (fifo_empty_nxt),
    .head_nxt_c  (head_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  // Next state plus per-cycle capture/handshake decisions.
  always_comb begin
    state_nxt = state_q;
    launch    = 1'b0;
    hs        = 1'b0;
    pop       = 1'b0;
    want      = 1'b0;
    push      = 1'b0;
    drop      = 1'b0;
    beat_nxt  = beat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          launch    = 1'b1;
          beat_nxt  = '0;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        hs   = bus.out_valid && bus.out_ready && !fifo_empty;
        pop  = hs && (beat_q == BEAT_W'(BEATS - 1));
        want = bus.sum_valid && (vec_cnt_q < vec_total_q);
        // A final-beat pop frees a slot for a vector arriving in the same cycle.
        push = want && (!fifo_full || pop);
        drop = want && fifo_full && !pop;
        if (hs) beat_nxt = pop ? '0 : beat_q + BEAT_W'(1);
        if (pop && (done_cnt_q == vec_total_q - CNT_W'(1))) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q        <= '0;
      vec_total_q   <= '0;
      vec_cnt_q     <= '0;
      done_cnt_q    <= '0;
      relu_q        <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      overflow      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
    end else begin
      beat_q        <= beat_nxt;
      busy          <= (state_nxt == ST_RUN);
      frame_done    <= (state_nxt == ST_DONE);
      bus.out_valid <= (state_nxt == ST_RUN) && !fifo_empty_nxt;
      bus.out_data  <= head_nxt[beat_nxt];
      if (launch) begin
        vec_total_q  <= CNT_W'(cfg_col) * CNT_W'(cfg_row);
        relu_q       <= relu_en;
        bus.out_addr <= cfg_base_addr;
        overflow     <= 1'b0;
        vec_cnt_q    <= '0;
        done_cnt_q   <= '0;
      end else begin
        if (hs)   bus.out_addr <= bus.out_addr + ADDR_W'(OUT_BYTES);
        if (push) vec_cnt_q    <= vec_cnt_q + CNT_W'(1);
        if (pop)  done_cnt_q   <= done_cnt_q + CNT_W'(1);
        if (drop) overflow     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psum_writeback.sv
// Bench for psum_writeback: directed scenarios plus random traffic against a queue-based model.
module tb_psum_writeback;
  import psum_writeback_pkg::*;

  localparam int NBEAT = int'(BEATS);
  localparam int BB    = int'(BEAT_BITS);
  localparam int NBYTE = int'(VEC_BYTES);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CFG_W-1:0]  cfg_col = '0;
  logic [CFG_W-1:0]  cfg_row = '0;
  logic [ADDR_W-1:0] cfg_base_addr = '0;
  logic              relu_en = 1'b0;
  logic              busy, frame_done, overflow;

  psum_writeback_if bus();

  psum_writeback dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_col       (cfg_col),
    .cfg_row       (cfg_row),
    .cfg_base_addr (cfg_base_addr),
    .relu_en       (relu_en),
    .bus           (bus),
    .busy          (busy),
    .frame_done    (frame_done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference model: frame state, queue of buffered vectors, beat position and address.
  int                m_state = 0;  // 0 idle, 1 running, 2 done
  logic [VEC_W-1:0]  m_q[$];
  int                m_beat, m_total, m_capt, m_compl;
  logic [ADDR_W-1:0] m_addr;
  bit                m_ovf, m_relu;

  function automatic logic [VEC_W-1:0] relu_model(input logic [VEC_W-1:0] v, input bit en);
    for (int i = 0; i < NBYTE; i++)
      if (en && v[8*i+7]) v[8*i +: 8] = 8'h00;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_q.delete(); m_beat = 0; m_total = 0; m_capt = 0; m_compl = 0;
    m_addr = '0; m_ovf = 0; m_relu = 0;
  endtask

  task automatic model_step();
    int sz;
    bit hs, last, take;
    case (m_state)
      0: if (start) begin
        m_state = 1; m_total = int'(cfg_col) * int'(cfg_row); m_relu = relu_en;
        m_addr = cfg_base_addr; m_ovf = 0; m_capt = 0; m_compl = 0; m_beat = 0;
      end
      1: begin
        sz   = m_q.size();
        hs   = (sz > 0) && bus.out_ready;
        last = hs && (m_beat == NBEAT - 1);
        take = 0;
        if (bus.sum_valid && (m_capt < m_total)) begin
          if (sz < 2 || last) take = 1;
          else m_ovf = 1;
        end
        if (hs) begin
          m_addr = m_addr + ADDR_W'(OUT_BYTES);
          m_beat++;
          if (m_beat == NBEAT) begin
            m_beat = 0;
            void'(m_q.pop_front());
            m_compl++;
          end
        end
        if (take) begin
          m_q.push_back(relu_model(bus.sum_in, m_relu));
          m_capt++;
        end
        if (m_compl == m_total) m_state = 2;
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic model_compare();
    bit ev;
    ev = (m_state == 1) && (m_q.size() > 0);
    chk1("busy", busy, m_state == 1);
    chk1("frame_done", frame_done, m_state == 2);
    chk1("overflow", overflow, m_ovf);
    chk1("out_valid", bus.out_valid, ev);
    if (ev) begin
      chkw("out_data", bus.out_data, m_q[0][m_beat*BB +: BB]);
      chkw("out_addr", 128'(bus.out_addr), 128'(m_addr));
    end
  endtask

  // Inputs are stable at the falling edge: compare current outputs, then predict the next edge.
  initial model_reset();
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      model_compare();
    end else begin
      model_compare();
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < int'(VEC_W) / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_start(input int col, input int row, input logic [ADDR_W-1:0] base, input logic relu);
    cfg_col = CFG_W'(col); cfg_row = CFG_W'(row); cfg_base_addr = base; relu_en = relu;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [VEC_W-1:0] v);
    bus.sum_in = v; bus.sum_valid = 1'b1;
    tick();
    bus.sum_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    chk1({name, "_valid_seen"}, seen, 1'b1);
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    chk1({name, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VEC_W-1:0] v;
    bus.sum_in = '0; bus.sum_valid = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    tick();

    // 1x1 frame, incrementing bytes, DRAM always ready.
    for (int i = 0; i < NBYTE; i++) v[8*i +: 8] = 8'(i);
    do_start(1, 1, 32'h1000, 1'b0);
    bus.out_ready = 1'b1;
    send(v);
    wait_valid("t1", 20);
    chkw("t1_beat0_data", bus.out_data, 128'h0F0E0D0C0B0A09080706050403020100);
    chkw("t1_beat0_addr", 128'(bus.out_addr), 128'h1000);
    repeat (7) @(negedge clk);
    chkw("t1_beat7_data", bus.out_data, 128'h7F7E7D7C7B7A79787776757473727170);
    chkw("t1_beat7_addr", 128'(bus.out_addr), 128'h1070);
    @(negedge clk);
    chk1("t1_frame_done", frame_done, 1'b1);
    chk1("t1_valid_low", bus.out_valid, 1'b0);
    tick();

    // ReLU on alternating 0x80 / 0x7F bytes.
    for (int i = 0; i < NBYTE; i++) v[8*i +: 8] = (i % 2 == 0) ? 8'h80 : 8'h7F;
    do_start(1, 1, 32'h0, 1'b1);
    send(v);
    wait_valid("t2", 20);
    chkw("t2_relu_beat0", bus.out_data, 128'h7F007F007F007F007F007F007F007F00);
    wait_done("t2", 40);
    tick();

    // Stalled DRAM: third vector dropped, frame can never complete.
    do_start(1, 3, 32'h4000, 1'b0);
    bus.out_ready = 1'b0;
    bus.sum_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.sum_in = rand_vec();
      tick();
    end
    bus.sum_valid = 1'b0;
    @(negedge clk);
    chk1("t3_overflow", overflow, 1'b1);
    tick();
    bus.out_ready = 1'b1;
    repeat (40) tick();
    chk1("t3_still_busy", busy, 1'b1);
    chk1("t3_drained", bus.out_valid, 1'b0);
    do_reset();

    // Toggling ready across two vectors.
    do_start(1, 2, 32'h8000, 1'b0);
    for (int c = 0; c < 60; c++) begin
      bus.out_ready = c[0];
      bus.sum_valid = (c < 2);
      bus.sum_in = rand_vec();
      tick();
    end
    bus.sum_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk1("t4_idle_after", busy, 1'b0);

    // Full FIFO with a vector arriving on the final-beat handshake.
    do_start(1, 3, 32'h100, 1'b0);
    send(rand_vec());
    send(rand_vec());
    repeat (6) tick();
    send(rand_vec());
    wait_done("t5", 60);
    chk1("t5_no_overflow", overflow, 1'b0);
    tick();

    // Random traffic, including an address wrap.
    for (int f = 0; f < 4; f++) begin
      do_start(int'($urandom_range(1, 3)), int'($urandom_range(1, 2)),
               (f == 0) ? 32'hFFFF_FFC0 : ($urandom & 32'hFFFF_FFF0), 1'($urandom));
      for (int c = 0; c < 300; c++) begin
        bus.sum_valid = ($urandom_range(0, 3) == 0);
        bus.sum_in    = rand_vec();
        bus.out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      bus.sum_valid = 1'b0;
      bus.out_ready = 1'b1;
      do_reset();
    end

    // Reset mid-beat, then a clean frame from a new base.
    do_start(1, 1, 32'h3000, 1'b0);
    bus.out_ready = 1'b0;
    send(rand_vec());
    wait_valid("t6", 20);
    #2;
    rst = 1'b1;
    #1;
    chk1("t6_rst_valid", bus.out_valid, 1'b0);
    chk1("t6_rst_busy", busy, 1'b0);
    @(posedge clk); @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    do_start(1, 1, 32'h2000, 1'b0);
    bus.out_ready = 1'b1;
    send(rand_vec());
    wait_valid("t6b", 20);
    chkw("t6_new_base", 128'(bus.out_addr), 128'h2000);
    wait_done("t6b", 40);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
